lightsaber_length_ctrl: RTL and testbench
=========================================

// Module: lightsaber_length_ctrl
// PURPOSE
//   Upstream sequencer for the lightsaber length register stage.
//   On ignite, ramps blade length from 0 up to a latched target, one decimal step per STEP_DIV clocks.
//   On a second ignite, ramps it back down to 0.
//   Drives len_int/len_dec plus a one-cycle len_en strobe that load the downstream Integer/Decimal registers.
// PARAMETERS
//   STEP_DIV  4   clocks per length step (>=1); prescaler width = clog2(STEP_DIV), min 1
//   DEC_TOP   63  largest decimal value; stepping past it carries into integer (fits 6-bit field)
//   MAX_INT   3   integer part of maximum blade length
//   MAX_DEC   0   decimal part of maximum blade length (<= DEC_TOP)
// PORTS
//   clk       in   1  rising-edge clock
//   rst       in   1  synchronous reset, active high
//   ignite    in   1  single-cycle request: start extend / start retract / reverse
//   tgt_int   in   2  target integer length, sampled when leaving OFF
//   tgt_dec   in   6  target decimal length, sampled when leaving OFF
//   len_int   out  2  current integer length (to register stage Ini)
//   len_dec   out  6  current decimal length (to register stage Deci)
//   len_en    out  1  high for exactly the cycle len_* changes (to register stage en)
//   busy      out  1  high in EXTEND or RETRACT
//   state     out  2  OFF=00 EXTEND=01 ON=10 RETRACT=11
// BEHAVIOUR
//   Reset: state=OFF; len_int=0, len_dec=0; len_en=0; busy=0; prescaler=0; latched target=0.00.
//   rst wins over all other inputs. Reset mid-ramp aborts immediately; no len_en on reset.
//   All outputs are registered.
//   Target latch (OFF + ignite):
//     - tgt_dec > DEC_TOP clamps to DEC_TOP.
//     - {tgt_int,tgt_dec} > {MAX_INT,MAX_DEC} clamps to the max.
//     - Comparison is lexicographic: integer part first, then decimal.
//   FSM transitions:
//     OFF    : ignite -> EXTEND, prescaler=0. Zero target -> EXTEND for one cycle, then ON with no step.
//     EXTEND : prescaler counts 0..STEP_DIV-1. At terminal count:
//                - len += 1 decimal step; len_dec==DEC_TOP -> len_dec=0, len_int+1.
//                - len_en=1 that cycle; prescaler wraps to 0.
//              If the new len == target -> ON in the same edge.
//              ignite -> RETRACT next cycle, prescaler=0, no step taken that cycle.
//     ON     : len held, len_en=0. ignite -> RETRACT, prescaler=0.
//     RETRACT: same timing as EXTEND, stepping down.
//                - len_dec==0 -> len_dec=DEC_TOP, len_int-1.
//                - len reaching 0.00 -> OFF in the same edge.
//              ignite -> EXTEND toward the latched target (no re-sample).
//   Latency: first len_en exactly STEP_DIV cycles after the ignite edge.
//     Full ramp = STEP_DIV * (distance in decimal steps) cycles.
//   Invariants:
//     - len never exceeds the latched target in EXTEND and never goes below 0.00 in RETRACT.
//     - len_dec is always <= DEC_TOP.
//   ignite held high is treated as one request per cycle; the bench drives pulses only.
// CONFIGURATION
//   LIGHTSABER_LEN_ADJUST_EN defined:
//     - Adds inputs adj_up and adj_down, each 1 bit, single-cycle.
//     - Active only in ON. adj_up: target and len += 1 step, len_en=1, saturating at {MAX_INT,MAX_DEC}.
//     - adj_down: target and len -= 1 step, len_en=1, saturating at 0.01 (blade stays lit).
//     - Both high, or ignite concurrent with either: adjust is ignored, ignite still acts.
//     - At saturation: no change and len_en=0.
//   Undefined: adj_up and adj_down ports do not exist. The target is fixed from latch until the next OFF.
// TESTING
//   1. rst; tgt=1.05, STEP_DIV=4, ignite -> len_en first at +4 cycles, len=0.01.
//      Reaches 1.05 (int=1, dec=5) after 69 steps = 276 cycles; state=ON, busy=0.
//   2. Carry: ramp through 0.63 -> next step gives int=1, dec=0.
//      Retract from 1.00 -> next step gives int=0, dec=63.
//   3. tgt_int=3, tgt_dec=40 with MAX=3.00 -> stops at int=3, dec=0; ON.
//      No len_en afterwards for 100 cycles.
//   4. ignite at len=0.10 in EXTEND -> RETRACT next cycle; 10 steps later len=0.00, state=OFF.
//      ignite again in RETRACT at 0.05 -> EXTEND toward the original target.
//   5. rst asserted mid-EXTEND at 0.20 -> next edge len=0.00, state=OFF, len_en=0.
//      Zero target + ignite -> ON after one cycle with no len_en.
//   6. With LIGHTSABER_LEN_ADJUST_EN at ON=1.00:
//      - adj_up -> 1.01 with len_en.
//      - adj_down x2 -> 0.63.
//      - adj_up+adj_down together -> no change.

Source files
------------

// File: rtl/lightsaber_length_ctrl.sv
// Blade length ramp sequencer: ignite extends to a latched target, a second ignite retracts to zero.
// Build macro LIGHTSABER_LEN_ADJUST_EN adds adj_up/adj_down single-step trimming while ON.
module lightsaber_length_ctrl #(
  parameter int STEP_DIV = 4,
  parameter int DEC_TOP  = 63,
  parameter int MAX_INT  = 3,
  parameter int MAX_DEC  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ignite,
  input  logic [1:0] tgt_int,
  input  logic [5:0] tgt_dec,
`ifdef LIGHTSABER_LEN_ADJUST_EN
  input  logic       adj_up,
  input  logic       adj_down,
`endif
  output logic [1:0] len_int,
  output logic [5:0] len_dec,
  output logic       len_en,
  output logic       busy,
  output logic [1:0] state
);

  localparam int            PW        = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PW-1:0] PRE_TOP   = PW'(STEP_DIV - 1);
  localparam logic [5:0]    DEC_TOP_V = 6'(DEC_TOP);
  localparam logic [1:0]    MAX_INT_V = 2'(MAX_INT);
  localparam logic [5:0]    MAX_DEC_V = 6'(MAX_DEC);

  typedef enum logic [1:0] {
    S_OFF     = 2'b00,
    S_EXTEND  = 2'b01,
    S_ON      = 2'b10,
    S_RETRACT = 2'b11
  } state_t;

  state_t        state_reg, state_next;
  logic [PW-1:0] pre_reg, pre_next;
  logic [1:0]    len_int_reg, len_int_next, tgt_int_reg, tgt_int_next;
  logic [5:0]    len_dec_reg, len_dec_next, tgt_dec_reg, tgt_dec_next;
  logic          len_en_reg, len_en_next, busy_reg, busy_next;

  logic [1:0] up_int, dn_int, cl_int;
  logic [5:0] up_dec, dn_dec, cl_dec;
  logic       at_tgt, up_at_tgt, at_zero, dn_at_zero, at_max, above_min, pre_done;
  logic       adj_up_req, adj_dn_req;

`ifdef LIGHTSABER_LEN_ADJUST_EN
  // Ignite or a contradictory pair cancels the adjust request.
  assign adj_up_req = adj_up & ~adj_down & ~ignite;
  assign adj_dn_req = adj_down & ~adj_up & ~ignite;
`else
  assign adj_up_req = 1'b0;
  assign adj_dn_req = 1'b0;
`endif

  // One decimal step up/down with carry/borrow between the two fields.
  always_comb begin
    if (len_dec_reg == DEC_TOP_V) begin
      up_int = len_int_reg + 2'd1;
      up_dec = 6'd0;
    end else begin
      up_int = len_int_reg;
      up_dec = len_dec_reg + 6'd1;
    end
    if (len_dec_reg == 6'd0) begin
      dn_int = len_int_reg - 2'd1;
      dn_dec = DEC_TOP_V;
    end else begin
      dn_int = len_int_reg;
      dn_dec = len_dec_reg - 6'd1;
    end
  end

  // Target clamp: decimal field first, then the whole value against the maximum.
  always_comb begin
    cl_int = tgt_int;
    cl_dec = (tgt_dec > DEC_TOP_V) ? DEC_TOP_V : tgt_dec;
    if ({cl_int, cl_dec} > {MAX_INT_V, MAX_DEC_V}) begin
      cl_int = MAX_INT_V;
      cl_dec = MAX_DEC_V;
    end
  end

  assign at_tgt     = ({len_int_reg, len_dec_reg} == {tgt_int_reg, tgt_dec_reg});
  assign up_at_tgt  = ({up_int, up_dec} == {tgt_int_reg, tgt_dec_reg});
  assign at_zero    = ({len_int_reg, len_dec_reg} == 8'd0);
  assign dn_at_zero = ({dn_int, dn_dec} == 8'd0);
  assign at_max     = ({len_int_reg, len_dec_reg} >= {MAX_INT_V, MAX_DEC_V});
  assign above_min  = ({len_int_reg, len_dec_reg} > 8'd1);
  assign pre_done   = (pre_reg == PRE_TOP);

  always_comb begin
    state_next   = state_reg;
    pre_next     = pre_reg;
    len_int_next = len_int_reg;
    len_dec_next = len_dec_reg;
    tgt_int_next = tgt_int_reg;
    tgt_dec_next = tgt_dec_reg;
    len_en_next  = 1'b0;

    case (state_reg)
      S_OFF: begin
        if (ignite) begin
          state_next   = S_EXTEND;
          pre_next     = '0;
          tgt_int_next = cl_int;
          tgt_dec_next = cl_dec;
        end
      end
      S_EXTEND: begin
        if (ignite) begin
          state_next = S_RETRACT;
          pre_next   = '0;
        end else if (at_tgt) begin
          // Covers a zero target and a reversal caught before its first step.
          state_next = S_ON;
          pre_next   = '0;
        end else if (pre_done) begin
          len_int_next = up_int;
          len_dec_next = up_dec;
          len_en_next  = 1'b1;
          pre_next     = '0;
          if (up_at_tgt) state_next = S_ON;
        end else begin
          pre_next = pre_reg + PW'(1);
        end
      end
      S_ON: begin
        if (ignite) begin
          state_next = S_RETRACT;
          pre_next   = '0;
        end else if (adj_up_req && !at_max) begin
          len_int_next = up_int;
          len_dec_next = up_dec;
          tgt_int_next = up_int;
          tgt_dec_next = up_dec;
          len_en_next  = 1'b1;
        end else if (adj_dn_req && above_min) begin
          len_int_next = dn_int;
          len_dec_next = dn_dec;
          tgt_int_next = dn_int;
          tgt_dec_next = dn_dec;
          len_en_next  = 1'b1;
        end
      end
      S_RETRACT: begin
        if (ignite) begin
          state_next = S_EXTEND;
          pre_next   = '0;
        end else if (at_zero) begin
          state_next = S_OFF;
          pre_next   = '0;
        end else if (pre_done) begin
          len_int_next = dn_int;
          len_dec_next = dn_dec;
          len_en_next  = 1'b1;
          pre_next     = '0;
          if (dn_at_zero) state_next = S_OFF;
        end else begin
          pre_next = pre_reg + PW'(1);
        end
      end
      default: state_next = S_OFF;
    endcase

    busy_next = (state_next == S_EXTEND) || (state_next == S_RETRACT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_OFF;
      pre_reg     <= '0;
      len_int_reg <= '0;
      len_dec_reg <= '0;
      tgt_int_reg <= '0;
      tgt_dec_reg <= '0;
      len_en_reg  <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pre_reg     <= pre_next;
      len_int_reg <= len_int_next;
      len_dec_reg <= len_dec_next;
      tgt_int_reg <= tgt_int_next;
      tgt_dec_reg <= tgt_dec_next;
      len_en_reg  <= len_en_next;
      busy_reg    <= busy_next;
    end
  end

  assign len_int = len_int_reg;
  assign len_dec = len_dec_reg;
  assign len_en  = len_en_reg;
  assign busy    = busy_reg;
  assign state   = state_reg;

endmodule

// File: tb/tb_lightsaber_length_ctrl.sv
// Bench for lightsaber_length_ctrl: ramp vector table, hand corner sequences, random ignite/reset
// traffic checked every cycle against a step-count reference model.
module tb_lightsaber_length_ctrl;

  localparam int STEP_DIV = 4;
  localparam int DEC_TOP  = 63;
  localparam int MAX_INT  = 3;
  localparam int MAX_DEC  = 0;
  localparam int BASE     = DEC_TOP + 1;
  localparam int MAXL     = MAX_INT * BASE + MAX_DEC;

  logic       clk    = 1'b0;
  logic       rst    = 1'b1;
  logic       ignite = 1'b0;
  logic [1:0] tgt_int = '0;
  logic [5:0] tgt_dec = '0;
`ifdef LIGHTSABER_LEN_ADJUST_EN
  logic       adj_up   = 1'b0;
  logic       adj_down = 1'b0;
`endif
  logic [1:0] len_int;
  logic [5:0] len_dec;
  logic       len_en;
  logic       busy;
  logic [1:0] state;

  lightsaber_length_ctrl #(
    .STEP_DIV(STEP_DIV), .DEC_TOP(DEC_TOP), .MAX_INT(MAX_INT), .MAX_DEC(MAX_DEC)
  ) dut (
    .clk(clk), .rst(rst), .ignite(ignite), .tgt_int(tgt_int), .tgt_dec(tgt_dec),
`ifdef LIGHTSABER_LEN_ADJUST_EN
    .adj_up(adj_up), .adj_down(adj_down),
`endif
    .len_int(len_int), .len_dec(len_dec), .len_en(len_en), .busy(busy), .state(state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: length and target as plain counts of decimal steps.
  int m_mode = 0;  // 0 off, 1 extend, 2 on, 3 retract
  int m_len  = 0;
  int m_tgt  = 0;
  int m_cnt  = 0;
  bit m_en   = 1'b0;

  function void model_clk();
    int d;
    m_en = 1'b0;
    if (rst) begin
      m_mode = 0; m_len = 0; m_tgt = 0; m_cnt = 0;
    end else begin
      case (m_mode)
        0: if (ignite) begin
             d = (int'(tgt_dec) > DEC_TOP) ? DEC_TOP : int'(tgt_dec);
             m_tgt = int'(tgt_int) * BASE + d;
             if (m_tgt > MAXL) m_tgt = MAXL;
             m_mode = 1; m_cnt = 0;
           end
        1: if (ignite) begin
             m_mode = 3; m_cnt = 0;
           end else if (m_len == m_tgt) begin
             m_mode = 2;
           end else begin
             m_cnt++;
             if (m_cnt == STEP_DIV) begin
               m_cnt = 0; m_len++; m_en = 1'b1;
               if (m_len == m_tgt) m_mode = 2;
             end
           end
        2: begin
             if (ignite) begin
               m_mode = 3; m_cnt = 0;
             end
`ifdef LIGHTSABER_LEN_ADJUST_EN
             else if (adj_up && !adj_down && m_len < MAXL) begin
               m_len++; m_tgt = m_len; m_en = 1'b1;
             end else if (adj_down && !adj_up && m_len > 1) begin
               m_len--; m_tgt = m_len; m_en = 1'b1;
             end
`endif
           end
        default: if (ignite) begin
             m_mode = 1; m_cnt = 0;
           end else if (m_len == 0) begin
             m_mode = 0;
           end else begin
             m_cnt++;
             if (m_cnt == STEP_DIV) begin
               m_cnt = 0; m_len--; m_en = 1'b1;
               if (m_len == 0) m_mode = 0;
             end
           end
      endcase
    end
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    int act, exp;
    @(posedge clk);
    model_clk();
    #1;
    act = int'({state, len_int, len_dec, len_en, busy});
    exp = (m_mode << 10) | ((m_len / BASE) << 8) | ((m_len % BASE) << 2)
        | (int'(m_en) << 1) | ((m_mode == 1 || m_mode == 3) ? 1 : 0);
    check("model", act, exp);
  endtask

  function automatic int cur_len();
    return int'(len_int) * BASE + int'(len_dec);
  endfunction

  task automatic do_reset();
    rst = 1'b1; ignite = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse();
    ignite = 1'b1;
    tick();
    ignite = 1'b0;
  endtask

  task automatic wait_len(input int l, input string name);
    bit found;
    found = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (cur_len() == l) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check(name, int'(found), 1);
  endtask

  task automatic wait_en(input string name);
    bit found;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (len_en) begin
        found = 1'b1;
        break;
      end
    end
    check(name, int'(found), 1);
  endtask

  typedef struct {
    int ti; int td; int exp_int; int exp_dec; int steps;
  } vec_t;
  vec_t vecs[6];

  int got_on, first_en, n_en, quiet_en, n_cyc;

  initial begin
    vecs[0] = '{1, 5, 1, 5, 69};
    vecs[1] = '{3, 40, 3, 0, 192};
    vecs[2] = '{0, 0, 0, 0, 0};
    vecs[3] = '{0, 63, 0, 63, 63};
    vecs[4] = '{2, 63, 2, 63, 191};
    vecs[5] = '{0, 1, 0, 1, 1};

    do_reset();
    check("rst_state", int'(state), 0);
    check("rst_len", cur_len(), 0);
    check("rst_en", int'(len_en), 0);
    check("rst_busy", int'(busy), 0);
    $display("reset: state=%0d len=%0d.%02d busy=%0d", state, len_int, len_dec, busy);

    // Ramp table: timing of first step, ramp length, final value, silence afterwards.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      tgt_int = 2'(vecs[v].ti);
      tgt_dec = 6'(vecs[v].td);
      pulse();
      got_on = -1; first_en = -1; n_en = 0;
      for (int c = 1; c <= 1000; c++) begin
        tick();
        if (len_en) begin
          n_en++;
          if (first_en < 0) first_en = c;
        end
        if (state == 2'b10) begin
          got_on = c;
          break;
        end
      end
      check("on_cycle", got_on, (vecs[v].steps == 0) ? 1 : vecs[v].steps * STEP_DIV);
      check("step_count", n_en, vecs[v].steps);
      check("final_int", int'(len_int), vecs[v].exp_int);
      check("final_dec", int'(len_dec), vecs[v].exp_dec);
      check("final_busy", int'(busy), 0);
      if (vecs[v].steps > 0) check("first_en", first_en, STEP_DIV);
      quiet_en = 0;
      for (int c = 0; c < 100; c++) begin
        tick();
        if (len_en) quiet_en++;
      end
      check("quiet_on", quiet_en, 0);
      $display("vec %0d: tgt=%0d.%02d len=%0d.%02d on_at=%0d steps=%0d",
               v, vecs[v].ti, vecs[v].td, len_int, len_dec, got_on, n_en);
    end

    // Carry up through 0.63 and borrow down from 1.00.
    do_reset();
    tgt_int = 2'd1; tgt_dec = 6'd0;
    pulse();
    wait_len(63, "wait_063");
    wait_en("carry_en");
    check("carry_int", int'(len_int), 1);
    check("carry_dec", int'(len_dec), 0);
    check("carry_on", int'(state), 2);
    pulse();
    wait_en("borrow_en");
    check("borrow_int", int'(len_int), 0);
    check("borrow_dec", int'(len_dec), 63);
    check("borrow_state", int'(state), 3);
    $display("carry/borrow: len=%0d.%02d state=%0d", len_int, len_dec, state);

    // Reverse mid-extend at 0.10, retract to zero.
    do_reset();
    tgt_int = 2'd1; tgt_dec = 6'd5;
    pulse();
    wait_len(10, "wait_010");
    pulse();
    check("rev_state", int'(state), 3);
    n_en = 0; n_cyc = 0;
    for (int c = 1; c <= 200; c++) begin
      tick();
      if (len_en) n_en++;
      if (state == 2'b00) begin
        n_cyc = c;
        break;
      end
    end
    check("rev_steps", n_en, 10);
    check("rev_cycles", n_cyc, 10 * STEP_DIV);
    check("rev_len", cur_len(), 0);
    $display("reverse: len=%0d.%02d state=%0d steps=%0d", len_int, len_dec, state, n_en);

    // Re-extend from RETRACT goes back to the original latched target.
    pulse();
    wait_len(10, "wait_010b");
    pulse();
    wait_len(5, "wait_005");
    tgt_int = 2'd0; tgt_dec = 6'd0;
    pulse();
    check("reext_state", int'(state), 1);
    got_on = -1;
    for (int c = 1; c <= 1000; c++) begin
      tick();
      if (state == 2'b10) begin
        got_on = c;
        break;
      end
    end
    check("reext_len", cur_len(), 1 * BASE + 5);
    check("reext_cycles", got_on, 64 * STEP_DIV);
    $display("re-extend: len=%0d.%02d state=%0d", len_int, len_dec, state);

    // Reset mid-ramp, then a zero target.
    do_reset();
    tgt_int = 2'd1; tgt_dec = 6'd5;
    pulse();
    wait_len(20, "wait_020");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_state", int'(state), 0);
    check("abort_len", cur_len(), 0);
    check("abort_en", int'(len_en), 0);
    tgt_int = 2'd0; tgt_dec = 6'd0;
    pulse();
    check("zero_ext", int'(state), 1);
    check("zero_en0", int'(len_en), 0);
    tick();
    check("zero_on", int'(state), 2);
    check("zero_en1", int'(len_en), 0);
    check("zero_len", cur_len(), 0);
    $display("abort+zero: len=%0d.%02d state=%0d", len_int, len_dec, state);

`ifdef LIGHTSABER_LEN_ADJUST_EN
    do_reset();
    tgt_int = 2'd1; tgt_dec = 6'd0;
    pulse();
    wait_len(BASE, "wait_100");
    tick();
    adj_up = 1'b1; tick(); adj_up = 1'b0;
    check("adj_up_len", cur_len(), BASE + 1);
    check("adj_up_en", int'(len_en), 1);
    adj_down = 1'b1; tick(); tick(); adj_down = 1'b0;
    check("adj_dn_len", cur_len(), 63);
    adj_up = 1'b1; adj_down = 1'b1; tick(); adj_up = 1'b0; adj_down = 1'b0;
    check("adj_both_len", cur_len(), 63);
    check("adj_both_en", int'(len_en), 0);
    $display("adjust: len=%0d.%02d state=%0d", len_int, len_dec, state);
`endif

    // Random ignite/reset traffic against the model.
    do_reset();
    for (int i = 0; i < 5000; i++) begin
      rst    = ($urandom_range(0, 399) == 0);
      ignite = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0) begin
        tgt_int = 2'($urandom);
        tgt_dec = 6'($urandom);
      end
`ifdef LIGHTSABER_LEN_ADJUST_EN
      adj_up   = ($urandom_range(0, 9) == 0);
      adj_down = ($urandom_range(0, 9) == 0);
`endif
      tick();
    end
    rst = 1'b0; ignite = 1'b0;
    $display("random: 5000 cycles, checks so far=%0d", total);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
